// File: rtl/seg_scan_driver_if.sv
// Bundles the load/control inputs and the registered display drives of
// seg_scan_driver; master is the CPU-side driver, slave is the display block.
interface seg_scan_driver_if;
    logic        en;
    logic [15:0] value;
    logic        value_valid;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [6:0]  display_atog;
    logic        display_dp;
    logic [3:0]  display_an;
    logic        frame_sync;

    modport master (
        output en, value, value_valid, blank_lz, dp_mask,
        input  display_atog, display_dp, display_an, frame_sync
    );

    modport slave (
        input  en, value, value_valid, blank_lz, dp_mask,
        output display_atog, display_dp, display_an, frame_sync
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a frame-aligned shadow
// register, leading-zero blanking and registered active-low drives.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50_000
) (
    input logic             clock,
    input logic             reset,
    seg_scan_driver_if.slave bus
);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_v_q, pend_v_d;
    logic          xfer_q, xfer_d;
    logic [6:0]    atog_q, atog_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          fsync_q, fsync_d;

    logic          tick;
    logic          boundary;
    logic [3:0]    nib;
    logic          blank;
    logic          zero3, zero2, zero1;
    logic [6:0]    seg;

    assign tick     = (pcnt_q == PW'(REFRESH_DIV - 1));
    assign boundary = tick && (idx_q == 2'd3);

    // Scan counters and load/shadow path
    always_comb begin
        pcnt_d    = tick ? '0 : pcnt_q + PW'(1);
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        xfer_d    = 1'b0;
        if (boundary) begin
            if (bus.value_valid) begin
                shadow_d = bus.value;
                xfer_d   = 1'b1;
            end else if (pend_v_q) begin
                shadow_d = pending_q;
                xfer_d   = 1'b1;
            end
            pend_v_d = 1'b0;
        end else if (bus.value_valid) begin
            pending_d = bus.value;
            pend_v_d  = 1'b1;
        end
    end

    // Digit select, blanking and decode feeding the output registers
    always_comb begin
        nib   = 4'(shadow_q >> {idx_q, 2'b00});
        zero3 = (shadow_q[15:12] == 4'h0);
        zero2 = zero3 && (shadow_q[11:8] == 4'h0);
        zero1 = zero2 && (shadow_q[7:4] == 4'h0);
        blank = 1'b0;
        case (idx_q)
            2'd3:    blank = bus.blank_lz && zero3;
            2'd2:    blank = bus.blank_lz && zero2;
            2'd1:    blank = bus.blank_lz && zero1;
            default: blank = 1'b0;
        endcase
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        an_d    = bus.en ? ~(4'b0001 << idx_q) : 4'b1111;
        atog_d  = (bus.en && !blank) ? seg : 7'b1111111;
        dp_d    = bus.en ? ~bus.dp_mask[idx_q] : 1'b1;
        // frame_sync is delayed one stage so it lines up with digit 0 of the new shadow
        fsync_d = xfer_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q    <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            pending_q <= '0;
            pend_v_q  <= 1'b0;
            xfer_q    <= 1'b0;
            an_q      <= '1;
            atog_q    <= '1;
            dp_q      <= 1'b1;
            fsync_q   <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            xfer_q    <= xfer_d;
            an_q      <= an_d;
            atog_q    <= atog_d;
            dp_q      <= dp_d;
            fsync_q   <= fsync_d;
        end
    end

    assign bus.display_an   = an_q;
    assign bus.display_atog = atog_q;
    assign bus.display_dp   = dp_q;
    assign bus.frame_sync   = fsync_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
  localparam int D = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] atog;
    logic       dp;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  seg_scan_driver_if bus ();

  seg_scan_driver #(.REFRESH_DIV(D)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          m_n       = 0;
  logic [15:0] m_shadow  = '0;
  logic [15:0] m_pending = '0;
  logic        m_pend_v  = 1'b0;
  logic        m_xfer    = 1'b0;

  logic        g_rst = 1'b1;
  logic        g_en  = 1'b1;
  logic        g_blz = 1'b0;
  logic [3:0]  g_dpm = 4'b0000;

  task automatic step(input logic vv, input logic [15:0] val);
    exp_t       e;
    logic [1:0] digit;
    logic [3:0] nibv;
    logic       blank;
    @(negedge clk);
    rst             = g_rst;
    bus.en          = g_en;
    bus.blank_lz    = g_blz;
    bus.dp_mask     = g_dpm;
    bus.value_valid = vv;
    bus.value       = val;
    if (g_rst) begin
      e = '{an: 4'b1111, atog: 7'b1111111, dp: 1'b1, fs: 1'b0};
      q.push_back(e);
      m_n = 0; m_shadow = '0; m_pending = '0; m_pend_v = 1'b0; m_xfer = 1'b0;
    end else begin
      m_n++;
      digit = 2'(((m_n - 1) / D) % 4);
      nibv  = 4'(m_shadow >> (4 * digit));
      blank = g_blz && (digit != 2'd0) && ((m_shadow >> (4 * digit)) == 16'h0);
      e.fs   = m_xfer;
      e.an   = g_en ? ~(4'b0001 << digit) : 4'b1111;
      e.atog = (g_en && !blank) ? seg_tab[nibv] : 7'b1111111;
      e.dp   = g_en ? ~g_dpm[digit] : 1'b1;
      q.push_back(e);
      m_xfer = 1'b0;
      if (m_n % (4 * D) == 0) begin
        if (vv) begin
          m_shadow = val; m_xfer = 1'b1;
        end else if (m_pend_v) begin
          m_shadow = m_pending; m_xfer = 1'b1;
        end
        m_pend_v = 1'b0;
      end else if (vv) begin
        m_pending = val; m_pend_v = 1'b1;
      end
    end
  endtask

  task automatic run(input int k);
    for (int unsigned i = 0; i < k; i++) step(1'b0, 16'h0);
  endtask

  task automatic check_reset();
    n_checks++;
    if (bus.display_an === 4'b1111 && bus.display_atog === 7'b1111111 &&
        bus.display_dp === 1'b1 && bus.frame_sync === 1'b0) begin
      n_pass++;
    end else begin
      $display("FAIL reset state: an=%b atog=%b dp=%b fs=%b",
               bus.display_an, bus.display_atog, bus.display_dp, bus.frame_sync);
    end
  endtask

  task automatic align_digit(input int d);
    for (int unsigned i = 0; i < 8 * D; i++) begin
      if ((m_n % D == 0) && ((m_n / D) % 4 == d)) break;
      step(1'b0, 16'h0);
    end
    n_checks++;
    if ((m_n % D == 0) && ((m_n / D) % 4 == d)) begin
      n_pass++;
    end else begin
      $display("FAIL align_digit(%0d): wait expired at m_n=%0d", d, m_n);
    end
  endtask

  task automatic align_boundary();
    for (int unsigned i = 0; i < 8 * D; i++) begin
      if ((m_n + 1) % (4 * D) == 0) break;
      step(1'b0, 16'h0);
    end
    n_checks++;
    if ((m_n + 1) % (4 * D) == 0) begin
      n_pass++;
    end else begin
      $display("FAIL align_boundary: wait expired at m_n=%0d", m_n);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if (bus.display_an === e.an && bus.display_atog === e.atog &&
            bus.display_dp === e.dp && bus.frame_sync === e.fs) begin
          n_pass++;
        end else begin
          $display("FAIL drive@cyc%0d: an=%b atog=%b dp=%b fs=%b, expected an=%b atog=%b dp=%b fs=%b",
                   cyc, bus.display_an, bus.display_atog, bus.display_dp, bus.frame_sync,
                   e.an, e.atog, e.dp, e.fs);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    bus.en = 1'b1; bus.blank_lz = 1'b0; bus.dp_mask = '0;
    bus.value = '0; bus.value_valid = 1'b0;

    g_rst = 1'b1;
    step(1'b1, 16'hDEAD);
    run(2);
    check_reset();
    g_rst = 1'b0;
    run(40);

    align_digit(1);
    step(1'b1, 16'h12AF);
    run(40);

    align_digit(0);
    step(1'b1, 16'h1111);
    run(3);
    step(1'b1, 16'h2222);
    run(40);

    align_boundary();
    step(1'b1, 16'h3333);
    run(20);

    g_blz = 1'b1;
    step(1'b1, 16'h0040);
    run(40);
    step(1'b1, 16'h0000);
    run(40);

    g_dpm = 4'b0100;
    run(20);
    g_en = 1'b0;
    run(10);
    g_en = 1'b1;
    run(20);

    step(1'b1, 16'hBEEF);
    run(3);
    g_rst = 1'b1;
    run(2);
    check_reset();
    g_rst = 1'b0;
    run(40);

    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) g_blz = ~g_blz;
      if ($urandom_range(0, 15) == 0) g_dpm = 4'($urandom);
      g_en  = ($urandom_range(0, 7) != 0);
      g_rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 7) == 0, 16'($urandom));
    end
    g_rst = 1'b0;
    run(20);

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
